// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and
// an optional second (skid) entry that keeps in_ready off the out_ready timing path.
module pipe_stage_reg #(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'(64'h0000_0000_0000_0013),
    parameter int                 SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_count
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_emit;
    logic              w_skid_full;
    logic [DATA_W-1:0] w_skid_data;

    assign w_accept = in_valid & w_in_ready;
    assign w_emit   = r_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_skid_full;
            logic [DATA_W-1:0] r_skid_data;
            logic              w_skid_load;

            // Main is busy and nobody is draining it: park the new word behind it.
            assign w_skid_load = ~r_skid_full & r_valid & ~w_emit & w_accept;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skid_full <= 1'b0;
                end else if (flush) begin
                    r_skid_full <= 1'b0;
                end else if (w_skid_load) begin
                    r_skid_full <= 1'b1;
                end else if (r_skid_full && w_emit) begin
                    r_skid_full <= 1'b0;
                end
            end

            // NOTE: payload storage needs no reset; r_skid_full alone says whether it is live.
            always_ff @(posedge clk) begin
                if (w_skid_load) begin
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_full = r_skid_full;
            assign w_skid_data = r_skid_data;
            assign w_in_ready  = ~r_skid_full & ~flush & ~rst;
        end else begin : g_no_skid
            assign w_skid_full = 1'b0;
            assign w_skid_data = BUBBLE;
            assign w_in_ready  = (~r_valid | out_ready) & ~flush & ~rst;
        end
    endgenerate

    // Main is reloaded with BUBBLE whenever it empties, so out_data needs no output mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (w_skid_full) begin
            if (w_emit) begin
                r_data <= w_skid_data;
            end
        end else if (w_accept && (!r_valid || w_emit)) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_emit) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_count = {1'b0, r_valid} + {1'b0, w_skid_full};

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer. It is the generalised successor to the fixed 64-bit IF/ID latch and is instantiated between any two stages of the 5-stage core: IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an arbitrary-width payload. It holds data under downstream stall, and on flush it drops in-flight entries and presents a configurable bubble word.

## Interface
- DATA_W, 64, payload width in bits (≥1).
- BUBBLE, {32'h0, 32'h0000_0013}, value driven on out_data whenever out_valid=0 (PC=0, NOP `addi x0,x0,0`).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload toward the next stage.
- out_count  output  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Accept: in_valid & in_ready at a rising edge. Emit: out_valid & out_ready at a rising edge.
- Storage consists of a main register, which drives out_data, and a skid register (SKID=1 only). Order is strictly FIFO.
- SKID=1:
  - in_ready = ~skid_full & ~flush. skid_full is a flop.
  - Empty + accept: data goes to main.
  - Main full, emit + accept: data goes to main.
  - Main full, no emit + accept: data goes to skid. skid_full=1.
  - Skid full + emit: the skid entry moves to main. skid_full=0.
- SKID=0:
  - in_ready = (~out_valid | out_ready) & ~flush.
  - Accept loads main. Emit without accept empties main.
- Empty main: out_data = BUBBLE. Main is reloaded with BUBBLE when it empties, so no combinational mux is placed on out_data.
- flush:
  - Highest priority over all other events. On the flush edge, both entries are cleared and main is loaded with BUBBLE.
  - in_ready is 0 during the flush cycle. An emit in that cycle still counts for the downstream stage, because its out_ready sampled the old data.
- out_count = out_valid + skid_full.

## Timing
- Reset (async assert, held while rst=1):
  - out_valid=0, out_data=BUBBLE, skid_full=0, out_count=0.
  - in_ready=0 while rst=1. After release, in_ready=1 (combinational from the cleared state).
- Latency: the first accepted word is visible on out_data/out_valid the cycle after acceptance.
- Throughput: one word per cycle sustained when out_ready=1.
- SKID=1: in_ready has no combinational path from out_ready. in_ready drops the cycle after the skid fills and rises the cycle after it drains.
- SKID=0: in_ready depends combinationally on out_ready and flush.
- Boundary cases:
  - Full (count=2), emit + in_valid: in_ready=0, so no accept. The skid entry moves to main and count=1.
  - Full, no emit: both entries hold and out_data stays stable.
  - Empty, in_valid=0, out_ready=1: no change.
  - Flush with count=2 and simultaneous in_valid: next cycle count=0, out_data=BUBBLE, and the input word is not taken.
  - Reset asserted mid-transfer: state clears immediately and asynchronously, and the in-flight word is lost.
- out_data and out_valid never change while out_valid=1 & out_ready=0, unless flush or rst.

## Test plan
- Reset: assert rst mid-cycle with count=2 → out_valid=0, out_data=64'h0000_0000_0000_0013, in_ready=0, out_count=0. Deassert → in_ready=1 next evaluation.
- Streaming (SKID=1): feed words 0x1000_0000_0000_00A1..A8 with out_ready=1 → out_data = A1..A8 in order, starting one cycle after the first accept, with no gaps.
- Stall: out_ready=0, push A1, A2, A3 → A1 on out_data, count=2, in_ready=0 from the cycle after A2 and A3 held off. Release out_ready → A2, then A3, with no loss or duplication.
- Flush: count=2 (A1, A2), pulse flush with in_valid=1 (A3) → next cycle out_valid=0, out_data=BUBBLE, count=0, A3 not accepted. The following cycle, in_ready=1 and A4 is accepted.
- SKID=0 with DATA_W=32, BUBBLE=32'h13: out_ready toggling every cycle with continuous in_valid → in_ready tracks ~out_valid|out_ready combinationally, count ≤1, and the output sequence matches the input sequence.
- Randomised valid/ready/flush against a reference FIFO model for 10k cycles → zero mismatches, and out_data is stable throughout every stall.
